// File: rtl/multicycle_adder.sv
// Sequential add/subtract core: CHUNK bits per clock, carry rippled across cycles.
// Optional signed-overflow output enabled by defining MULTICYCLE_ADDER_OVF_EN.
module multicycle_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
`ifdef MULTICYCLE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N     = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  generate
    if ((WIDTH < 1) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_param
      $fatal(1, "multicycle_adder: CHUNK must be >= 1 and divide WIDTH");
    end
  endgenerate

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic             c_q, c_d, cout_q, cout_d, busy_q, busy_d, done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef MULTICYCLE_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [CHUNK-1:0] ch_sum_s;
  logic [CHUNK:0]   ch_carry_s;
  logic [WIDTH-1:0] ch_ext_s;
  logic [WIDTH-1:0] res_shift_s;

  // Ripple-carry add of the low chunk, result placed at the top of the shift register
  always_comb begin
    ch_carry_s    = '0;
    ch_sum_s      = '0;
    ch_carry_s[0] = c_q;
    for (int i = 0; i < CHUNK; i++) begin
      ch_sum_s[i]     = a_q[i] ^ b_q[i] ^ ch_carry_s[i];
      ch_carry_s[i+1] = (ch_carry_s[i] & (a_q[i] ^ b_q[i])) | (a_q[i] & b_q[i]);
    end
    ch_ext_s              = '0;
    ch_ext_s[CHUNK-1:0]   = ch_sum_s;
    res_shift_s           = (res_q >> CHUNK) | (ch_ext_s << (WIDTH - CHUNK));
  end

  // Next-state and datapath update for the IDLE/RUN sequencer
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef MULTICYCLE_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          c_d     = sub ? 1'b1 : cin;
          cnt_d   = '0;
          res_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d   = a_q >> CHUNK;
        b_d   = b_q >> CHUNK;
        c_d   = ch_carry_s[CHUNK];
        cnt_d = cnt_q + CNT_W'(1);
        res_d = res_shift_s;
        if (cnt_q == LAST) begin
          sum_d   = res_shift_s;
          cout_d  = ch_carry_s[CHUNK];
`ifdef MULTICYCLE_ADDER_OVF_EN
          // Carry into the MSB is the carry entering the top bit of the last chunk
          ovf_d   = ch_carry_s[CHUNK-1] ^ ch_carry_s[CHUNK];
`endif
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MULTICYCLE_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MULTICYCLE_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef MULTICYCLE_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
